// File: rtl/ps2_writer.sv
// ps2_writer: host-to-device PS/2 transmitter.
//
// Sends one command byte to a PS/2 keyboard or mouse. The pads are open-drain; this block only
// produces active-high pull-low enables. The shared receive path must ignore traffic while busy.
//
// Frame: start 0, d0..d7 LSB first, odd parity (~^data), stop 1, then device ack (data low).
//
// Ports:
//   CLK50MHZ     in   system clock, rising edge
//   RST          in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock pad level (asynchronous)
//   ps2_data     in   raw PS/2 data pad level (asynchronous)
//   data_in[7:0] in   byte to send, sampled on an accepted send
//   send         in   single-cycle request strobe, ignored while busy
//   ps2_clk_oe   out  1 pulls the clock pad low
//   ps2_data_oe  out  1 pulls the data pad low
//   busy         out  high in every state except idle
//   done         out  one-cycle pulse on device ack
//   err          out  one-cycle pulse on missing ack (or watchdog expiry)
//
// Optional feature: define PS2_WRITER_TIMEOUT_EN to compile in a watchdog that aborts a frame
// whose SHIFT+ACK phase, or whose RECOVER phase, exceeds TIMEOUT_CYCLES.

module ps2_writer #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StRecover
  } state_e;

  // Input conditioning: 2-flop synchronizers plus a delayed copy for falling-edge detection.
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       clk_s;
  logic       data_s;
  logic       clk_neg;

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign clk_neg = clk_prev_q & ~clk_s;

  state_e          state_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [3:0]      bit_cnt_q;
  // {stop, parity, d7..d0}; shifting in ones makes the stop bit release the data pad.
  logic [9:0]      shift_q;

`ifdef PS2_WRITER_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wd_q;
`endif

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      inh_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef PS2_WRITER_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          if (send) begin
            shift_q    <= {1'b1, ~^data_in, data_in};
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state_q    <= StInhibit;
          end
        end

        StInhibit: begin
          if (inh_cnt_q == InhLast) begin
            // Start bit goes out one cycle before the clock is released.
            ps2_data_oe <= 1'b1;
            state_q     <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + InhW'(1);
          end
        end

        StReq: begin
          ps2_clk_oe <= 1'b0;
          bit_cnt_q  <= '0;
          state_q    <= StShift;
        end

        StShift: begin
          if (clk_neg) begin
            ps2_data_oe <= ~shift_q[0];
            shift_q     <= {1'b1, shift_q[9:1]};
            bit_cnt_q   <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
              state_q <= StAck;
            end
          end
        end

        StAck: begin
          if (clk_neg) begin
            if (data_s) begin
              err <= 1'b1;
            end else begin
              done <= 1'b1;
            end
            state_q <= StRecover;
          end
        end

        StRecover: begin
          if (clk_s && data_s) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase

`ifdef PS2_WRITER_TIMEOUT_EN
      // Watchdog: spans SHIFT+ACK from SHIFT entry, restarts for RECOVER. Expiry overrides the
      // normal next state and suppresses any coincident done pulse.
      if (state_q == StShift || state_q == StAck || state_q == StRecover) begin
        if (wd_q == WdLast) begin
          err         <= 1'b1;
          done        <= 1'b0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          state_q     <= StIdle;
          wd_q        <= '0;
        end else if (state_q == StAck && clk_neg) begin
          wd_q <= '0;
        end else begin
          wd_q <= wd_q + WdW'(1);
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_writer.sv
// Testbench for ps2_writer: a behavioural PS/2 device clocks frames out of the host and the
// received bits are compared against values derived from the frame rules.

module tb_ps2_writer;

  localparam int unsigned Inh = 40;
  localparam int unsigned To  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] data_in = '0;
  logic       send = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       clk_pad, data_pad;

  // Open-drain pads: either side may pull low.
  assign clk_pad  = dev_clk & ~ps2_clk_oe;
  assign data_pad = dev_data & ~ps2_data_oe;

  ps2_writer #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .CLK50MHZ   (clk),
    .RST        (rst_n),
    .ps2_clk    (clk_pad),
    .ps2_data   (data_pad),
    .data_in    (data_in),
    .send       (send),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic ref_parity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Send one byte and play the device side. rx returns the 10 bits sampled on rising edges.
  task automatic run_frame(input logic [7:0] d, input bit ack, input int unsigned h,
                           input bit poke, output logic [9:0] rx);
    int unsigned n;
    int unsigned both;
    rx = '0;
    @(negedge clk);
    data_in = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    data_in = 8'($urandom);
    chk("busy_after_send", {31'd0, busy}, 32'd1);
    n = 0;
    both = 0;
    while (ps2_clk_oe && n < Inh + 10) begin
      n++;
      if (ps2_data_oe) both++;
      @(negedge clk);
    end
    chk("clk_inhibit_len", n, Inh + 1);
    chk("req_overlap", both, 32'd1);
    n = 0;
    while (!(clk_pad && !data_pad) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("start_bit", {30'd0, clk_pad, data_pad}, 32'd2);
    for (int k = 1; k <= 11; k++) begin
      repeat (h) @(negedge clk);
      dev_clk = 1'b0;
      if (poke && k == 3) begin
        data_in = 8'hFF;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (h - 1) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (k <= 10) rx[k-1] = data_pad;
      if (k == 10 && ack) dev_data = 1'b0;
    end
    dev_data = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_release", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         poke;
    logic       exp_parity;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [9:0]  rx;
    int          d0, e0, n;
    logic [7:0]  rd;
    bit          rack;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hF4, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hAA, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b1};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, done, err, 1'b0}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || ps2_clk_oe) n++;
    end
    chk("idle_after_reset", n, 32'd0);

    // Table-driven frames.
    foreach (vecs[i]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[i].data, vecs[i].ack, 10, vecs[i].poke, rx);
      chk("rx_byte", {24'd0, rx[7:0]}, {24'd0, vecs[i].data});
      chk("rx_parity", {31'd0, rx[8]}, {31'd0, vecs[i].exp_parity});
      chk("rx_stop", {31'd0, rx[9]}, 32'd1);
      chk("done_pulses", done_cnt - d0, vecs[i].ack ? 32'd1 : 32'd0);
      chk("err_pulses", err_cnt - e0, vecs[i].ack ? 32'd0 : 32'd1);
      if (vecs[i].poke) begin
        n = 0;
        repeat (Inh + 20) begin
          @(negedge clk);
          if (ps2_clk_oe || busy) n++;
        end
        chk("no_second_frame", n, 32'd0);
      end
    end

    // Randomized frames against the reference rules.
    for (int r = 0; r < 20; r++) begin
      rd = 8'($urandom);
      rack = ($urandom_range(3, 0) != 0);
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(rd, rack, $urandom_range(12, 6), 1'b0, rx);
      chk("rnd_byte", {24'd0, rx[7:0]}, {24'd0, rd});
      chk("rnd_parity", {31'd0, rx[8]}, {31'd0, ref_parity(rd)});
      chk("rnd_stop", {31'd0, rx[9]}, 32'd1);
      chk("rnd_done", done_cnt - d0, rack ? 32'd1 : 32'd0);
      chk("rnd_err", err_cnt - e0, rack ? 32'd0 : 32'd1);
    end

    // Asynchronous reset in the middle of SHIFT.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    data_in = 8'h3C;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (!(clk_pad && !data_pad) && n < Inh + 50) begin
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge clk);
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("async_rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    dev_clk = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (Inh + 50) begin
      @(negedge clk);
      if (busy || ps2_clk_oe || ps2_data_oe) n++;
    end
    chk("idle_after_abort", n, 32'd0);
    chk("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);

`ifdef PS2_WRITER_TIMEOUT_EN
    // Watchdog: device never clocks.
    e0 = err_cnt;
    @(negedge clk);
    data_in = 8'hA5;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < Inh + 10) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!err && n < To + 50) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_latency", n, To);
    @(negedge clk);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("timeout_err_count", err_cnt - e0, 32'd1);
`endif

    chk("done_err_exclusive", both_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
